// File: rtl/jump_pkg.sv
// Shared types and the relative-offset table for the jump control stage.
// JUMP_LINK_EN (optional macro) enables CALL/RET through a single link register.
package jump_pkg;

    localparam int LUT_DW    = 12;
    localparam int LUT_DEPTH = 16;

    typedef enum logic [2:0] {
        BR_NOP  = 3'd0,
        BR_JMP  = 3'd1,
        BR_BZ   = 3'd2,
        BR_BNZ  = 3'd3,
        BR_BC   = 3'd4,
        BR_CALL = 3'd5,
        BR_RET  = 3'd6,
        BR_HALT = 3'd7
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Signed relative offsets; edit this table to retarget a program.
    localparam logic [LUT_DW-1:0] LUT_INIT [LUT_DEPTH] = '{
        12'h001, 12'h002, 12'hFFE, 12'hFFC,
        12'h003, 12'h007, 12'hFF8, 12'h010,
        12'hFF0, 12'h020, 12'h7FF, 12'h800,
        12'h004, 12'hFFF, 12'h005, 12'hFE0
    };

endpackage

// File: rtl/jump_lut.sv
// Combinational offset lookup: index -> sign-extended D-bit relative offset.
// Table depth is fixed at 16 entries, so LUT_AW is expected to be 4.
module jump_lut
    import jump_pkg::*;
#(
    parameter int D      = 12,
    parameter int LUT_AW = 4
) (
    input  logic [LUT_AW-1:0] lut_idx,
    output logic [D-1:0]      offset
);

    logic [LUT_DW-1:0] entry;

    always_comb begin
        entry  = LUT_INIT[lut_idx];
        offset = D'($signed(entry));
    end

endmodule

// File: rtl/jump_ctrl.sv
// Run/halt control upstream of the PC: branch decision, relative target, cycle counter.
// Define JUMP_LINK_EN to enable CALL/RET through a single link register.
//
//   state     | meaning
//   ST_IDLE   | after reset, PC held until start
//   ST_RUN    | decoding br_op every cycle
//   ST_HALTED | HALT seen, PC held, done=1 until start
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int D      = 12,
    parameter int LUT_AW = 4,
    parameter int CW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        br_op,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic [D-1:0]      prog_ctr,
    output logic              jump_en,
    output logic [D-1:0]      target,
    output logic              done,
    output logic              running,
    output logic [CW-1:0]     cyc_cnt
);

    state_t         state_q, state_d;
    logic           zero_q, zero_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [D-1:0]   lut_off;
    br_op_t         op;

`ifdef JUMP_LINK_EN
    logic [D-1:0]   link_q, link_d;
`else
    logic           unused_prog_ctr;
    assign unused_prog_ctr = ^prog_ctr;
`endif

    assign op = br_op_t'(br_op);

    jump_lut #(
        .D      (D),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .lut_idx (lut_idx),
        .offset  (lut_off)
    );

    // Branches see only the registered flags; a same-cycle flag_we lands after the decision.
    always_comb begin
        zero_d    = flag_we ? alu_zero  : zero_q;
        carry_d   = flag_we ? alu_carry : carry_q;
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == ST_RUN && cyc_cnt_q != {CW{1'b1}}) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        jump_en = 1'b1;
        target  = '0;
`ifdef JUMP_LINK_EN
        link_d  = link_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                case (op)
                    BR_JMP: target = lut_off;
                    BR_BZ: begin
                        if (zero_q) target  = lut_off;
                        else        jump_en = 1'b0;
                    end
                    BR_BNZ: begin
                        if (!zero_q) target  = lut_off;
                        else         jump_en = 1'b0;
                    end
                    BR_BC: begin
                        if (carry_q) target  = lut_off;
                        else         jump_en = 1'b0;
                    end
`ifdef JUMP_LINK_EN
                    BR_CALL: begin
                        target = lut_off;
                        link_d = prog_ctr + 1'b1;
                    end
                    BR_RET: target = link_q - prog_ctr;
`endif
                    BR_HALT: state_d = ST_HALTED;
                    default: jump_en = 1'b0;
                endcase
            end
            ST_HALTED: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            cyc_cnt_q <= '0;
`ifdef JUMP_LINK_EN
            link_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            cyc_cnt_q <= cyc_cnt_d;
`ifdef JUMP_LINK_EN
            link_q    <= link_d;
`endif
        end
    end

    assign done    = (state_q == ST_HALTED);
    assign running = (state_q == ST_RUN);
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: per-cycle behavioural model plus literal pins.
// Honours JUMP_LINK_EN when the design is built with it.
module tb_jump_ctrl;

    localparam int D  = 12;
    localparam int AW = 4;
    localparam int CW = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, flag_we, alu_zero, alu_carry;
    logic [2:0]    br_op;
    logic [AW-1:0] lut_idx;
    logic [D-1:0]  prog_ctr;
    logic          jump_en, done, running;
    logic [D-1:0]  target;
    logic [CW-1:0] cyc_cnt;

    jump_ctrl #(.D(D), .LUT_AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .br_op     (br_op),
        .lut_idx   (lut_idx),
        .flag_we   (flag_we),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .prog_ctr  (prog_ctr),
        .jump_en   (jump_en),
        .target    (target),
        .done      (done),
        .running   (running),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 clk = ~clk;

    // Reference offsets written out as signed integers.
    int lut_ref [16] = '{1, 2, -2, -4, 3, 7, -8, 16, -16, 32, 2047, -2048, 4, -1, 5, -32};

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 0 idle, 1 run, 2 halted.
    int            m_state = 0;
    bit            m_zero = 0, m_carry = 0;
    int            m_cnt = 0;
    int            m_link = 0;

    logic          s_je;
    logic [D-1:0]  s_tgt;
    logic [CW-1:0] p_cnt;
    logic          p_done, p_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic rst, input logic st, input logic [2:0] op,
                        input logic [AW-1:0] idx, input logic fwe, input logic az,
                        input logic ac, input logic [D-1:0] pc);
        bit e_je;
        int e_tgt;
        @(negedge clk);
        reset = rst; start = st; br_op = op; lut_idx = idx;
        flag_we = fwe; alu_zero = az; alu_carry = ac; prog_ctr = pc;
        #1;
        e_je = 1; e_tgt = 0;
        if (m_state == 1) begin
            case (op)
                3'd1: e_tgt = lut_ref[idx];
                3'd2: if (m_zero)  e_tgt = lut_ref[idx]; else e_je = 0;
                3'd3: if (!m_zero) e_tgt = lut_ref[idx]; else e_je = 0;
                3'd4: if (m_carry) e_tgt = lut_ref[idx]; else e_je = 0;
`ifdef JUMP_LINK_EN
                3'd5: e_tgt = lut_ref[idx];
                3'd6: e_tgt = m_link - int'(pc);
`endif
                3'd7: e_tgt = 0;
                default: e_je = 0;
            endcase
        end
        s_je = jump_en; s_tgt = target;
        check("jump_en", 32'(jump_en), 32'(e_je));
        check("target",  32'(target),  32'(e_tgt & 'hFFF));
        check("done",    32'(done),    32'(m_state == 2));
        check("running", 32'(running), 32'(m_state == 1));
        check("cyc_cnt", 32'(cyc_cnt), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_zero = 0; m_carry = 0; m_cnt = 0; m_link = 0;
        end else begin
            if (m_state == 1 && m_cnt < CNT_MAX) m_cnt++;
            if (fwe) begin m_zero = az; m_carry = ac; end
            case (m_state)
                0: if (st) m_state = 1;
                1: begin
                    if (op == 3'd7) m_state = 2;
`ifdef JUMP_LINK_EN
                    if (op == 3'd5) m_link = (int'(pc) + 1) & 'hFFF;
`endif
                end
                default: if (st) m_state = 1;
            endcase
        end
        #1;
        p_cnt = cyc_cnt; p_done = done; p_run = running;
    endtask

    logic [2:0] op_tab [8] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd5, 3'd6, 3'd3};

    initial begin
        reset = 1; start = 0; br_op = 0; lut_idx = 0;
        flag_we = 0; alu_zero = 0; alu_carry = 0; prog_ctr = 0;

        step(1, 0, 3'd1, 4'd5, 0, 0, 0, 12'h000);
        step(1, 0, 3'd1, 4'd5, 0, 0, 0, 12'h000);
        step(0, 0, 3'd1, 4'd5, 0, 0, 0, 12'h000);
        check("idle_hold_je", 32'(s_je), 32'd1);
        check("idle_hold_tgt", 32'(s_tgt), 32'd0);

        // Run nine cycles, then reset mid-run.
        step(0, 1, 3'd0, 4'd0, 0, 0, 0, 12'h000);
        for (int i = 0; i < 9; i++) step(0, 0, 3'd0, 4'd0, 0, 0, 0, 12'(i));
        check("cnt_nine", 32'(p_cnt), 32'd9);
        step(1, 0, 3'd1, 4'd5, 0, 0, 0, 12'h000);
        check("rst_cnt", 32'(p_cnt), 32'd0);
        check("rst_done", 32'(p_done), 32'd0);
        check("rst_run", 32'(p_run), 32'd0);
        step(0, 0, 3'd1, 4'd5, 0, 0, 0, 12'h000);
        check("rst_je", 32'(s_je), 32'd1);
        check("rst_tgt", 32'(s_tgt), 32'd0);

        // start, then JMP +7.
        step(0, 1, 3'd0, 4'd0, 0, 0, 0, 12'h000);
        step(0, 0, 3'd1, 4'd5, 0, 0, 0, 12'h001);
        check("jmp_je", 32'(s_je), 32'd1);
        check("jmp_tgt", 32'(s_tgt), 32'h007);
        check("jmp_cnt", 32'(p_cnt), 32'd1);

        // Same-cycle flag write does not affect the branch.
        step(0, 0, 3'd2, 4'd3, 1, 1, 0, 12'h008);
        check("bz_stale", 32'(s_je), 32'd0);
        step(0, 0, 3'd2, 4'd3, 0, 0, 0, 12'h009);
        check("bz_taken", 32'(s_tgt), 32'hFFC);

        step(0, 0, 3'd0, 4'd0, 1, 0, 0, 12'h005);
        step(0, 0, 3'd3, 4'd0, 0, 0, 0, 12'h006);
        check("bnz_tgt", 32'(s_tgt), 32'h001);
        step(0, 0, 3'd4, 4'd5, 0, 0, 0, 12'h007);
        check("bc_nt", 32'(s_je), 32'd0);
        step(0, 0, 3'd0, 4'd0, 1, 0, 1, 12'h008);
        step(0, 0, 3'd4, 4'd13, 0, 0, 0, 12'h009);
        check("bc_tgt", 32'(s_tgt), 32'hFFF);

        // CALL / RET.
        step(0, 0, 3'd5, 4'd5, 0, 0, 0, 12'h010);
`ifdef JUMP_LINK_EN
        check("call_tgt", 32'(s_tgt), 32'h007);
        step(0, 0, 3'd6, 4'd0, 0, 0, 0, 12'h020);
        check("ret_tgt", 32'(s_tgt), 32'hFF1);
`else
        check("call_nop", 32'(s_je), 32'd0);
        step(0, 0, 3'd6, 4'd0, 0, 0, 0, 12'h020);
        check("ret_nop", 32'(s_je), 32'd0);
`endif

        // Mixed patterns with varied flags and indices.
        for (int i = 0; i < 16; i++)
            step(0, i[0], op_tab[i % 8], AW'(i), i[1], i[2], i[0], 12'(i * 37));

        // HALT, hold, resume.
        step(0, 0, 3'd7, 4'd5, 0, 0, 0, 12'h100);
        check("halt_je", 32'(s_je), 32'd1);
        check("halt_tgt", 32'(s_tgt), 32'd0);
        check("halt_done", 32'(p_done), 32'd1);
        begin
            logic [CW-1:0] frozen;
            frozen = p_cnt;
            step(0, 0, 3'd1, 4'd5, 0, 0, 0, 12'h100);
            step(0, 0, 3'd1, 4'd5, 0, 0, 0, 12'h100);
            check("halt_frozen", 32'(p_cnt), 32'(frozen));
        end
        step(0, 1, 3'd7, 4'd0, 0, 0, 0, 12'h100);
        check("resume_run", 32'(p_run), 32'd1);

        // Saturation of the cycle counter.
        for (int i = 0; i < CNT_MAX + 8; i++) step(0, 0, 3'd0, 4'd0, 0, 0, 0, 12'(i));
        check("cnt_sat", 32'(p_cnt), 32'(CNT_MAX));

        // Reset while halted.
        step(0, 0, 3'd7, 4'd0, 0, 0, 0, 12'h000);
        step(1, 1, 3'd0, 4'd0, 0, 0, 0, 12'h000);
        check("rst_halted_done", 32'(p_done), 32'd0);
        step(0, 0, 3'd1, 4'd7, 0, 0, 0, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Control stage directly upstream of the program counter. Each cycle it decides `jump_en` and the relative `target` the PC adds to `prog_ctr`.
- Holds the registered ALU flags, a constant relative-offset lookup table (LUT) indexed by an instruction field, and the run/halt state machine.
- Also provides a saturating executed-cycle counter for the bench and host.
- Holding the PC is done by asserting `jump_en` with `target = 0`.

Parameters:
- D, 12, PC / target width; must match the PC stage.
- LUT_AW, 4, LUT index width (2^LUT_AW entries).
- CW, 16, cycle counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  leave IDLE or HALTED and enter RUN
- br_op  in  3  branch opcode from the decoded instruction
- lut_idx  in  LUT_AW  offset LUT index from the instruction
- flag_we  in  1  latch ALU flags this cycle
- alu_zero  in  1  ALU zero flag
- alu_carry  in  1  ALU carry flag
- prog_ctr  in  D  current PC value (used only with JUMP_LINK_EN)
- jump_en  out  1  PC adds `target` instead of 1
- target  out  D  relative offset, two's complement, modulo 2^D
- done  out  1  state == HALTED
- running  out  1  state == RUN
- cyc_cnt  out  CW  number of cycles spent in RUN, saturating

Behaviour:
- Reset (synchronous, active-high, takes priority at any point including mid-branch or while HALTED):
  - state <= IDLE; zero_q, carry_q, cyc_cnt, link_q <= 0.
  - Outputs after the reset edge: jump_en=1, target=0, done=0, running=0.
- br_op encoding: 0 NOP, 1 JMP, 2 BZ, 3 BNZ, 4 BC, 5 CALL, 6 RET, 7 HALT.
- Flags: zero_q/carry_q load alu_zero/alu_carry on a clock edge when flag_we=1.
  - A branch always evaluates the registered flags (zero-cycle decision, no forwarding).
  - flag_we in the same cycle as a branch affects only later branches.
- jump_en and target are combinational from state, br_op, lut_idx, the registered flags and link_q. There is no added latency: the PC sees the decision at the same clock edge.
- IDLE:
  - jump_en=1, target=0 (PC held); br_op ignored.
  - start=1 -> RUN next cycle.
- RUN:
  - Taken branch: jump_en=1, target=LUT[lut_idx] (sign-extended to D).
    - JMP: always taken.
    - BZ: taken when zero_q=1.
    - BNZ: taken when zero_q=0.
    - BC: taken when carry_q=1.
  - Not taken, or NOP: jump_en=0, target=0.
  - HALT: jump_en=1, target=0; next state HALTED. The PC stays on the HALT instruction.
  - CALL/RET without the optional feature: treated as NOP.
  - start is ignored in RUN.
- HALTED:
  - jump_en=1, target=0, done=1.
  - start=1 -> RUN. The first RUN cycle decodes the HALT at prog_ctr again, so a resumed program needs NOP-following semantics supplied by the host; start is level-sampled.
- cyc_cnt increments by 1 on every clock edge in RUN, including the HALT cycle. It holds at 2^CW-1 and clears only on reset.
- Target arithmetic is modulo 2^D; wrap-around past 0 or 2^D-1 is legal.

Optional Feature:
- Macro: JUMP_LINK_EN.
- Defined:
  - CALL: taken like JMP and link_q <= prog_ctr + 1 (mod 2^D).
  - RET: jump_en=1, target = link_q - prog_ctr (mod 2^D).
  - Single-entry link register; a nested CALL overwrites it.
- Undefined: link_q is absent, CALL and RET decode as NOP, and the prog_ctr input is unused (the port remains).

Decomposition:
- Package jump_pkg:
  - br_op_t enum (the 8 opcodes).
  - state_t enum (IDLE, RUN, HALTED).
  - Localparam LUT_INIT array of 2^LUT_AW D-bit signed offsets; entry 3 = -4 (12'hFFC), entry 5 = +7, entry 0 = +1.
- One sub-module, jump_lut: combinational index -> offset read of LUT_INIT, so the program can change without touching the FSM.

Test Plan:
- Reset asserted during RUN with cyc_cnt=9 -> next cycle state IDLE, jump_en=1, target=0, cyc_cnt=0, done=0.
- start=1 then JMP with lut_idx=5 -> jump_en=1, target=12'h007; cyc_cnt=1 after that edge.
- flag_we=1, alu_zero=1 with BZ lut_idx=3 in the same cycle -> not taken (jump_en=0). BZ on the next cycle -> target=12'hFFC.
- BNZ with zero_q=0 -> taken; BC with carry_q=0 -> jump_en=0.
- HALT in RUN -> jump_en=1, target=0 that cycle, done=1 next cycle, cyc_cnt frozen; start in HALTED -> running=1.
- JUMP_LINK_EN: CALL at prog_ctr=12'h010, lut_idx=5 -> link_q=12'h011; RET at prog_ctr=12'h020 -> target=12'hFF1.
